leaf_stream_adapter: RTL and testbench

// Parametrised buffering/control shim between the leaf_interface user-side vld/ack ports and an HLS

---
 rtl/leaf_stream_adapter.sv | 175 +++++++++++++++++
 tb/tb_leaf_stream_adapter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_stream_adapter.sv
// leaf_stream_adapter
//   Buffering and run-control shim between the leaf_interface user-side vld/ack ports and an HLS
//   operator's AXI-stream ports. Every port has its own FIFO in both directions. A small FSM
//   drives ap_start and reports a completed run only after the operator's output FIFOs have
//   drained into the leaf_interface.
//
// Ports
//   i_clk, i_reset                 clock (rising edge), asynchronous active-high reset
//   i_ap_start_in                  run request from the top level
//   i_dout_leaf_interface2user     leaf data in, port i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   i_vld_interface2user           leaf data valid, per input port
//   o_ack_user2interface           accept toward the leaf, per input port (input FIFO not full)
//   o_in_tdata/o_in_tvalid         operator Input_i stream (valid = input FIFO not empty)
//   i_in_tready                    operator Input_i ready
//   i_out_tdata/i_out_tvalid       operator Output_i stream
//   o_out_tready                   operator Output_i ready (output FIFO not full)
//   o_din_leaf_user2interface      data toward the leaf_interface
//   o_vld_user2interface           valid toward the leaf_interface (output FIFO not empty)
//   i_ack_interface2user           leaf_interface accept
//   o_ap_start_out, i_ap_done_in   operator run control (ap_done is a one-cycle pulse)
//   o_busy                         FSM not idle
//   o_run_count                    completed runs, saturating
module leaf_stream_adapter #(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_IN_PORTS  = 1,
  parameter int unsigned NUM_OUT_PORTS = 1,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned START_MODE    = 0
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_ap_start_in,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    i_dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                 i_vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]                 o_ack_user2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    o_in_tdata,
  output logic [NUM_IN_PORTS-1:0]                 o_in_tvalid,
  input  logic [NUM_IN_PORTS-1:0]                 i_in_tready,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   i_out_tdata,
  input  logic [NUM_OUT_PORTS-1:0]                i_out_tvalid,
  output logic [NUM_OUT_PORTS-1:0]                o_out_tready,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   o_din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                o_vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                i_ack_interface2user,
  output logic                                    o_ap_start_out,
  input  logic                                    i_ap_done_in,
  output logic                                    o_busy,
  output logic [15:0]                             o_run_count
);

  localparam int unsigned NumPorts  = NUM_IN_PORTS + NUM_OUT_PORTS;
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam bit          LevelStart = (START_MODE == 0);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  // All FIFOs share one implementation: input ports occupy the low indices, output ports the
  // high ones. Write side is the producer (leaf or operator), read side the consumer.
  logic [NumPorts-1:0]              w_wr_vld;
  logic [NumPorts-1:0]              w_rd_rdy;
  logic [NumPorts-1:0]              w_full;
  logic [NumPorts-1:0]              w_empty;
  logic [NumPorts*PAYLOAD_BITS-1:0] w_wr_data;
  logic [NumPorts*PAYLOAD_BITS-1:0] w_rd_data;

  assign w_wr_vld  = {i_out_tvalid, i_vld_interface2user};
  assign w_rd_rdy  = {i_ack_interface2user, i_in_tready};
  assign w_wr_data = {i_out_tdata, i_dout_leaf_interface2user};

  for (genvar g = 0; g < NumPorts; g++) begin : g_fifo
    logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]         r_wptr;
    logic [PtrW-1:0]         r_rptr;
    logic                    r_full;
    logic                    r_empty;
    logic                    w_push;
    logic                    w_pop;

    // Ready is !full, so a push never lands on a full FIFO even if it pops in the same cycle.
    assign w_push = w_wr_vld[g] & ~r_full;
    assign w_pop  = w_rd_rdy[g] & ~r_empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_full  <= 1'b0;
        r_empty <= 1'b1;
        for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
          r_mem[k] <= '0;
        end
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= w_wr_data[g*PAYLOAD_BITS +: PAYLOAD_BITS];
          r_wptr        <= r_wptr + PtrW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PtrW'(1);
        end
        // Flags only move on an unbalanced cycle; push+pop keeps the occupancy.
        if (w_push && !w_pop) begin
          r_empty <= 1'b0;
          r_full  <= ((r_wptr + PtrW'(1)) == r_rptr);
        end else if (w_pop && !w_push) begin
          r_full  <= 1'b0;
          r_empty <= ((r_rptr + PtrW'(1)) == r_wptr);
        end
      end
    end

    assign w_full[g]                                  = r_full;
    assign w_empty[g]                                 = r_empty;
    assign w_rd_data[g*PAYLOAD_BITS +: PAYLOAD_BITS]  = r_mem[r_rptr];
  end

  // Accepts are held low while reset is asserted, not just after the first edge.
  assign o_ack_user2interface = ~w_full[NUM_IN_PORTS-1:0] & {NUM_IN_PORTS{~i_reset}};
  assign o_in_tvalid          = ~w_empty[NUM_IN_PORTS-1:0];
  assign o_in_tdata           = w_rd_data[NUM_IN_PORTS*PAYLOAD_BITS-1:0];
  assign o_out_tready         = ~w_full[NumPorts-1:NUM_IN_PORTS] & {NUM_OUT_PORTS{~i_reset}};
  assign o_vld_user2interface = ~w_empty[NumPorts-1:NUM_IN_PORTS];
  assign o_din_leaf_user2interface = w_rd_data[NumPorts*PAYLOAD_BITS-1:NUM_IN_PORTS*PAYLOAD_BITS];

  // Run control
  logic [1:0]  r_state;
  logic [1:0]  w_state_d;
  logic [15:0] r_run_count;
  logic [15:0] w_run_count_d;
  logic        w_out_drained;

  assign w_out_drained = &w_empty[NumPorts-1:NUM_IN_PORTS];

  always_comb begin
    w_state_d     = r_state;
    w_run_count_d = r_run_count;
    case (r_state)
      StIdle: begin
        if (i_ap_start_in) w_state_d = StStart;
      end
      StStart: begin
        w_state_d = StRun;
      end
      StRun: begin
        if (i_ap_done_in) w_state_d = StDrain;
      end
      StDrain: begin
        if (w_out_drained) begin
          if (r_run_count != 16'hFFFF) w_run_count_d = r_run_count + 16'd1;
          w_state_d = (LevelStart && i_ap_start_in) ? StStart : StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_run_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_run_count <= w_run_count_d;
    end
  end

  // Level mode keeps ap_start up through RUN while requested; pulse mode only in START.
  assign o_ap_start_out = (r_state == StStart) ||
                          (LevelStart && (r_state == StRun) && i_ap_start_in);
  assign o_busy         = (r_state != StIdle);
  assign o_run_count    = r_run_count;

endmodule

// File: tb/tb_leaf_stream_adapter.sv
// Directed bench for leaf_stream_adapter: a 2x2-port level-start instance (A) and a 1x1-port
// pulse-start instance (B), both with 4-entry FIFOs.
module tb_leaf_stream_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: 2 in, 2 out, level start
  logic        a_start, a_done, a_apstart, a_busy;
  logic [63:0] a_din, a_itdata, a_otdata, a_dout;
  logic [1:0]  a_vld, a_ack, a_itvalid, a_itready, a_otvalid, a_otready, a_ovld, a_oack;
  logic [15:0] a_rc;

  leaf_stream_adapter #(
    .PAYLOAD_BITS(32), .NUM_IN_PORTS(2), .NUM_OUT_PORTS(2), .FIFO_DEPTH(4), .START_MODE(0)
  ) u_dut_a (
    .i_clk                      (clk),
    .i_reset                    (rst),
    .i_ap_start_in              (a_start),
    .i_dout_leaf_interface2user (a_din),
    .i_vld_interface2user       (a_vld),
    .o_ack_user2interface       (a_ack),
    .o_in_tdata                 (a_itdata),
    .o_in_tvalid                (a_itvalid),
    .i_in_tready                (a_itready),
    .i_out_tdata                (a_otdata),
    .i_out_tvalid               (a_otvalid),
    .o_out_tready               (a_otready),
    .o_din_leaf_user2interface  (a_dout),
    .o_vld_user2interface       (a_ovld),
    .i_ack_interface2user       (a_oack),
    .o_ap_start_out             (a_apstart),
    .i_ap_done_in               (a_done),
    .o_busy                     (a_busy),
    .o_run_count                (a_rc)
  );

  // Instance B: 1 in, 1 out, pulse start
  logic        b_start, b_done, b_apstart, b_busy;
  logic [31:0] b_din, b_itdata, b_otdata, b_dout;
  logic        b_vld, b_ack, b_itvalid, b_itready, b_otvalid, b_otready, b_ovld, b_oack;
  logic [15:0] b_rc;

  leaf_stream_adapter #(
    .PAYLOAD_BITS(32), .NUM_IN_PORTS(1), .NUM_OUT_PORTS(1), .FIFO_DEPTH(4), .START_MODE(1)
  ) u_dut_b (
    .i_clk                      (clk),
    .i_reset                    (rst),
    .i_ap_start_in              (b_start),
    .i_dout_leaf_interface2user (b_din),
    .i_vld_interface2user       (b_vld),
    .o_ack_user2interface       (b_ack),
    .o_in_tdata                 (b_itdata),
    .o_in_tvalid                (b_itvalid),
    .i_in_tready                (b_itready),
    .i_out_tdata                (b_otdata),
    .i_out_tvalid               (b_otvalid),
    .o_out_tready               (b_otready),
    .o_din_leaf_user2interface  (b_dout),
    .o_vld_user2interface       (b_ovld),
    .i_ack_interface2user       (b_oack),
    .o_ap_start_out             (b_apstart),
    .i_ap_done_in               (b_done),
    .o_busy                     (b_busy),
    .o_run_count                (b_rc)
  );

  function automatic logic [31:0] in_word(input int p, input int k);
    return 32'h1000_0000 * (p + 1) + k;
  endfunction

  function automatic logic [31:0] out_word(input int p, input int k);
    return 32'h7000_0000 + (p << 24) + k;
  endfunction

  initial begin
    int w, exp_o, cyc;
    logic acc;
    int sent_i[2], got_i[2], sent_o[2], got_o[2];
    localparam int NBeats = 1000;

    rst = 1'b1;
    a_start = 0; a_done = 0; a_din = '0; a_vld = '0; a_itready = '0;
    a_otdata = '0; a_otvalid = '0; a_oack = '0;
    b_start = 0; b_done = 0; b_din = '0; b_vld = 0; b_itready = 0;
    b_otdata = '0; b_otvalid = 0; b_oack = 0;

    // Reset state
    #12;
    chk("rst_ack", a_ack, 2'b00);
    chk("rst_otready", a_otready, 2'b00);
    chk("rst_itvalid", a_itvalid, 2'b00);
    chk("rst_ovld", a_ovld, 2'b00);
    chk("rst_apstart", a_apstart, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_runcount", a_rc, 16'd0);
    chk("rst_itdata", a_itdata, 64'd0);
    chk("rst_b_busy", b_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_ack", a_ack, 2'b11);
    chk("post_rst_itvalid", a_itvalid, 2'b00);

    // Fill / back-pressure on input port 0
    for (int k = 1; k <= 4; k++) begin
      a_din[31:0] = k;
      a_vld = 2'b01;
      chk("t2_ack_open", a_ack[0], 1'b1);
      tick();
    end
    a_din[31:0] = 5;
    chk("t2_ack_full", a_ack[0], 1'b0);
    chk("t2_tvalid", a_itvalid[0], 1'b1);
    chk("t2_head", a_itdata[31:0], 32'h1);
    tick();
    chk("t2_ack_held", a_ack[0], 1'b0);
    a_itready[0] = 1'b1;
    w = 5;
    exp_o = 1;
    for (int c = 0; c < 12; c++) begin
      a_din[31:0] = w;
      a_vld[0] = (w <= 6);
      if (a_itvalid[0]) begin
        chk("t2_order", a_itdata[31:0], exp_o);
        exp_o++;
      end
      acc = a_vld[0] & a_ack[0];
      tick();
      if (acc) w++;
    end
    chk("t2_all_out", exp_o, 7);
    chk("t2_all_in", w, 7);
    chk("t2_empty", a_itvalid[0], 1'b0);
    a_vld = '0;
    a_itready = '0;

    // Simultaneous push/pop on input port 1 at occupancy 3 (wraps the pointers)
    for (int k = 0; k < 3; k++) begin
      a_din[63:32] = 32'hA0 + k;
      a_vld = 2'b10;
      tick();
    end
    a_itready[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_din[63:32] = 32'hA3 + i;
      chk("t3_ack", a_ack[1], 1'b1);
      chk("t3_tvalid", a_itvalid[1], 1'b1);
      chk("t3_data", a_itdata[63:32], 32'hA0 + i);
      tick();
    end
    a_itready[1] = 1'b0;
    a_din[63:32] = 32'hAD;
    chk("t3_count3_ack", a_ack[1], 1'b1);
    tick();
    a_vld = '0;
    chk("t3_count4_full", a_ack[1], 1'b0);
    a_itready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_vld", a_itvalid[1], 1'b1);
      chk("t3_drain", a_itdata[63:32], 32'hAA + i);
      tick();
    end
    chk("t3_empty", a_itvalid[1], 1'b0);
    a_itready = '0;

    // Level-start restarts on A
    a_start = 1'b1;
    tick();
    chk("t5_start", a_apstart, 1'b1);
    chk("t5_busy", a_busy, 1'b1);
    tick();
    chk("t5_run_level", a_apstart, 1'b1);
    for (int r = 1; r <= 3; r++) begin
      a_done = 1'b1;
      tick();
      a_done = 1'b0;
      chk("t5_drain_apstart", a_apstart, 1'b0);
      chk("t5_drain_busy", a_busy, 1'b1);
      if (r == 3) a_start = 1'b0;
      tick();
      chk("t5_runcount", a_rc, r);
      chk("t5_restart", a_apstart, (r < 3));
      if (r < 3) tick();
    end
    chk("t5_idle", a_busy, 1'b0);
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    tick();
    chk("t5_done_ignored_busy", a_busy, 1'b0);
    chk("t5_done_ignored_count", a_rc, 16'd3);

    // Pulse-start run on B with two words still queued toward the leaf
    b_otvalid = 1'b1;
    b_otdata = 32'h11;
    tick();
    b_otdata = 32'h22;
    tick();
    b_otvalid = 1'b0;
    chk("t4_q_vld", b_ovld, 1'b1);
    chk("t4_q_head", b_dout, 32'h11);
    b_start = 1'b1;
    tick();
    chk("t4_pulse", b_apstart, 1'b1);
    chk("t4_busy", b_busy, 1'b1);
    tick();
    chk("t4_pulse_end", b_apstart, 1'b0);
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    b_start = 1'b0;
    chk("t4_drain_busy", b_busy, 1'b1);
    tick();
    chk("t4_hold_busy", b_busy, 1'b1);
    chk("t4_hold_count", b_rc, 16'd0);
    b_oack = 1'b1;
    chk("t4_word0", b_dout, 32'h11);
    tick();
    chk("t4_word1", b_dout, 32'h22);
    chk("t4_word1_vld", b_ovld, 1'b1);
    tick();
    b_oack = 1'b0;
    chk("t4_drained_vld", b_ovld, 1'b0);
    chk("t4_still_busy", b_busy, 1'b1);
    tick();
    chk("t4_runcount", b_rc, 16'd1);
    chk("t4_idle", b_busy, 1'b0);
    chk("t4_apstart_idle", b_apstart, 1'b0);

    // Reset in the middle of a burst and a run
    a_vld = 2'b11;
    a_din = {32'hBEEF_0001, 32'hBEEF_0002};
    tick();
    tick();
    a_start = 1'b1;
    tick();
    chk("t1_pre_busy", a_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t1_ack", a_ack, 2'b00);
    chk("t1_itvalid", a_itvalid, 2'b00);
    chk("t1_ovld", a_ovld, 2'b00);
    chk("t1_apstart", a_apstart, 1'b0);
    chk("t1_busy", a_busy, 1'b0);
    chk("t1_runcount", a_rc, 16'd0);
    chk("t1_b_runcount", b_rc, 16'd0);
    a_vld = '0;
    a_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t1_post_itvalid", a_itvalid, 2'b00);
    chk("t1_post_ack", a_ack, 2'b11);
    chk("t1_post_busy", a_busy, 1'b0);

    // Random traffic on all four A FIFOs
    for (int p = 0; p < 2; p++) begin
      sent_i[p] = 0; got_i[p] = 0; sent_o[p] = 0; got_o[p] = 0;
    end
    cyc = 0;
    while (cyc < 20000 && (got_i[0] < NBeats || got_i[1] < NBeats ||
                           got_o[0] < NBeats || got_o[1] < NBeats)) begin
      for (int p = 0; p < 2; p++) begin
        a_vld[p]              = (sent_i[p] < NBeats) && ($urandom_range(0, 1) == 1);
        a_din[p*32 +: 32]     = in_word(p, sent_i[p]);
        a_itready[p]          = ($urandom_range(0, 1) == 1);
        a_otvalid[p]          = (sent_o[p] < NBeats) && ($urandom_range(0, 1) == 1);
        a_otdata[p*32 +: 32]  = out_word(p, sent_o[p]);
        a_oack[p]             = ($urandom_range(0, 1) == 1);
      end
      for (int p = 0; p < 2; p++) begin
        if (a_vld[p] && a_ack[p]) sent_i[p]++;
        if (a_otvalid[p] && a_otready[p]) sent_o[p]++;
        if (a_itvalid[p] && a_itready[p]) begin
          chk("t6_in_order", a_itdata[p*32 +: 32], in_word(p, got_i[p]));
          got_i[p]++;
        end
        if (a_ovld[p] && a_oack[p]) begin
          chk("t6_out_order", a_dout[p*32 +: 32], out_word(p, got_o[p]));
          got_o[p]++;
        end
      end
      tick();
      cyc++;
    end
    a_vld = '0; a_itready = '0; a_otvalid = '0; a_oack = '0;
    for (int p = 0; p < 2; p++) begin
      chk("t6_in_beats", got_i[p], NBeats);
      chk("t6_out_beats", got_o[p], NBeats);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
